// File: rtl/glyph_pkg.sv
// Shared constants, address-width helper and FSM state encoding for glyph_writer.
// The readback states exist only when GLYPH_WRITER_READBACK_EN is defined.
package glyph_pkg;
  localparam int CHAR_ROWS = 16;
  localparam int CHAR_W    = 8;
  localparam int CODE_W    = 7;

  function automatic int addr_w(input int code_w);
    return code_w + 4;
  endfunction

`ifdef GLYPH_WRITER_READBACK_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_VRD,
    ST_VCMP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_t;
`endif
endpackage

// File: rtl/glyph_writer_bit_packer.sv
// MSB-first serial-to-parallel packer: 8-bit shift register, 3-bit bit counter and
// a byte_full flag that marks the cycle in which the eighth bit is shifted in.
module bit_packer
  import glyph_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [CHAR_W-1:0] byte_out,
  output logic              byte_full
);

  logic [CHAR_W-1:0] shreg_q, shreg_d;
  logic [2:0]        cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[CHAR_W-2:0], bit_in};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  assign byte_full = shift_en && !clr && (cnt_q == 3'd7);
  assign byte_out  = shreg_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/glyph_writer.sv
// Loads a CHAR_ROWS x 8 glyph from a serial bit stream into character RAM at {code, row}.
// Optional GLYPH_WRITER_READBACK_EN adds a read-verify of every written row.
module glyph_writer #(
  parameter int CHAR_ROWS = 16,
  parameter int CODE_W    = 7
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [CODE_W-1:0]                      charCode,
  input  logic                                   bitIn,
  input  logic                                   bitValid,
  output logic                                   bitReady,
  output logic                                   ramWrEn,
  output logic [glyph_pkg::addr_w(CODE_W)-1:0]   ramAddr,
  output logic [glyph_pkg::CHAR_W-1:0]           ramWrData,
  output logic                                   busy,
  output logic                                   done
`ifdef GLYPH_WRITER_READBACK_EN
  ,
  output logic                                   ramRdEn,
  input  logic [glyph_pkg::CHAR_W-1:0]           ramRdData,
  output logic                                   verifyErr
`endif
);
  import glyph_pkg::*;

  localparam logic [3:0] LAST_ROW = 4'(CHAR_ROWS - 1);

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [3:0]         row_q, row_d;
  logic               row_end;
  logic               pk_clr, pk_shift, pk_full;
  logic [CHAR_W-1:0]  pk_byte;
`ifdef GLYPH_WRITER_READBACK_EN
  logic               err_q, err_d;
  logic               rd_mismatch;
`endif

  bit_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clr       (pk_clr),
    .shift_en  (pk_shift),
    .bit_in    (bitIn),
    .byte_out  (pk_byte),
    .byte_full (pk_full)
  );

  assign ramAddr   = {code_q, row_q};
  assign ramWrData = pk_byte;

`ifdef GLYPH_WRITER_READBACK_EN
  // The flag is visible already in the compare cycle, then held by err_q.
  assign rd_mismatch = (state_q == ST_VCMP) && (ramRdData != pk_byte);
  assign verifyErr   = err_q | rd_mismatch;
`endif

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    row_d    = row_q;
    row_end  = 1'b0;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    bitReady = 1'b0;
    ramWrEn  = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
`ifdef GLYPH_WRITER_READBACK_EN
    ramRdEn  = 1'b0;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          code_d  = charCode;
          row_d   = '0;
          pk_clr  = 1'b1;
`ifdef GLYPH_WRITER_READBACK_EN
          err_d   = 1'b0;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bitReady = 1'b1;
        pk_shift = bitValid;
        if (pk_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ramWrEn = 1'b1;
`ifdef GLYPH_WRITER_READBACK_EN
        state_d = ST_VRD;
`else
        row_end = 1'b1;
`endif
      end
`ifdef GLYPH_WRITER_READBACK_EN
      ST_VRD: begin
        ramRdEn = 1'b1;
        state_d = ST_VCMP;
      end
      ST_VCMP: begin
        if (rd_mismatch) err_d = 1'b1;
        row_end = 1'b1;
      end
`endif
      ST_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Terminal row finishes the load; the row counter never wraps.
    if (row_end) begin
      if (row_q == LAST_ROW) begin
        state_d = ST_DONE;
      end else begin
        row_d   = row_q + 4'd1;
        pk_clr  = 1'b1;
        state_d = ST_LOAD;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      row_q   <= '0;
`ifdef GLYPH_WRITER_READBACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      row_q   <= row_d;
`ifdef GLYPH_WRITER_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_glyph_writer.sv
// Self-checking bench for glyph_writer: transaction-level reference model plus literal pins.
// Builds with or without GLYPH_WRITER_READBACK_EN.
`timescale 1ns/1ps
module tb_glyph_writer;
`ifdef GLYPH_WRITER_READBACK_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 1;
`endif
  localparam int ROW_CYC  = 8 + GAP;
  localparam int DONE_OFF = ROW_CYC * 16 + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  charCode = '0;
  logic        bitIn = 1'b0;
  logic        bitValid = 1'b0;
  logic        bitReady, ramWrEn, busy, done;
  logic [10:0] ramAddr;
  logic [7:0]  ramWrData;
`ifdef GLYPH_WRITER_READBACK_EN
  logic        ramRdEn, verifyErr;
  logic [7:0]  ramRdData;
  logic [7:0]  mem [2048];
  bit          corrupt7 = 1'b0;
`endif

  always #5 clock = ~clock;

  glyph_writer #(.CHAR_ROWS(16), .CODE_W(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .charCode  (charCode),
    .bitIn     (bitIn),
    .bitValid  (bitValid),
    .bitReady  (bitReady),
    .ramWrEn   (ramWrEn),
    .ramAddr   (ramAddr),
    .ramWrData (ramWrData),
    .busy      (busy),
    .done      (done)
`ifdef GLYPH_WRITER_READBACK_EN
    ,
    .ramRdEn   (ramRdEn),
    .ramRdData (ramRdData),
    .verifyErr (verifyErr)
`endif
  );

`ifdef GLYPH_WRITER_READBACK_EN
  // Character RAM: one-cycle read latency, optional corruption of row 7 readback.
  always @(posedge clock) begin
    if (ramWrEn) mem[ramAddr] <= ramWrData;
    if (ramRdEn) ramRdData <= (corrupt7 && ramAddr[3:0] == 4'd7) ? 8'hFF : mem[ramAddr];
  end
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  // Reference model: a load is 128 accepted bits; every 8th bit is followed by
  // GAP non-accepting cycles (write, then read and compare with readback), then done.
  bit         chk_en = 1'b0;
  bit         m_active = 1'b0, m_done_now = 1'b0, m_err = 1'b0;
  logic [6:0] m_code = '0;
  int         m_taken = 0, m_gap = 0, start_cyc = 0;
  bit         m_acc [128];

  logic [7:0]  rows [16];
  logic [10:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  bit          seen_done;
  int          done_off, err_first;
  logic        busy_at_done, err_at_done;

  function automatic logic [7:0] row_byte(input int r);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++)
      if (m_acc[8*r+i]) b = b + 8'(1 << (7 - i));
    return b;
  endfunction

  always @(negedge clock) begin
    logic        e_rdy, e_wr, e_rd, e_done, e_busy, e_err;
    logic [10:0] e_addr;
    logic [7:0]  e_byte, rd_val;
    int          ph;
    if (chk_en) begin
      e_rdy = 0; e_wr = 0; e_rd = 0; e_done = 0; e_busy = 0; e_err = m_err;
      e_addr = '0; e_byte = '0; ph = -1;
`ifdef GLYPH_WRITER_READBACK_EN
      rd_val = ramRdData;
`else
      rd_val = '0;
`endif
      if (m_done_now) e_done = 1;
      else if (m_active) begin
        e_busy = 1;
        if (m_gap == 0) e_rdy = 1;
        else begin
          ph     = GAP - m_gap;
          e_byte = row_byte(m_taken / 8 - 1);
          e_addr = {m_code, 4'(m_taken / 8 - 1)};
          if (ph == 0) e_wr = 1;
          if (ph == 1) e_rd = 1;
          if (ph == 2 && rd_val !== e_byte) e_err = 1;
        end
      end
      check("bitReady", bitReady, e_rdy);
      check("ramWrEn", ramWrEn, e_wr);
      check("done", done, e_done);
      check("busy", busy, e_busy);
      if (e_wr) begin
        check("wr_addr", ramAddr, e_addr);
        check("wr_data", ramWrData, e_byte);
      end
`ifdef GLYPH_WRITER_READBACK_EN
      check("ramRdEn", ramRdEn, e_rd);
      check("verifyErr", verifyErr, e_err);
      if (e_rd) check("rd_addr", ramAddr, e_addr);
      if (verifyErr === 1'b1 && err_first < 0) err_first = cyc - start_cyc;
      err_at_done = verifyErr;
`else
      err_at_done = 1'b0;
`endif
      if (ramWrEn === 1'b1) begin
        wr_addr.push_back(ramAddr);
        wr_data.push_back(ramWrData);
      end
      if (done === 1'b1 && !seen_done) begin
        seen_done = 1;
        done_off = cyc - start_cyc;
        busy_at_done = busy;
      end
      // advance the model by the inputs of this cycle
      if (reset) begin
        m_active = 0; m_gap = 0; m_done_now = 0; m_err = 0;
      end else if (m_done_now) begin
        m_done_now = 0; m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_code = charCode; m_taken = 0; m_gap = 0; m_err = 0;
          start_cyc = cyc;
        end
      end else if (m_gap > 0) begin
        if (ph == 2 && rd_val !== e_byte) m_err = 1;
        m_gap--;
        if (m_gap == 0 && m_taken == 128) m_done_now = 1;
      end else if (bitValid) begin
        m_acc[m_taken] = bitIn;
        m_taken++;
        if (m_taken % 8 == 0) m_gap = GAP;
      end
    end
  end

  // Caller is positioned #1 after a posedge; returns in the same position.
  task automatic run_load(input logic [6:0] code, input bit rand_valid, input int stall_at,
                          input int stall_len, input int ign_at, input int rst_after);
    int n, stall_left, post_rst;
    bit stalled, did_rst;
    wr_addr.delete(); wr_data.delete();
    seen_done = 0; done_off = -1; err_first = -1;
    start = 1; charCode = code; bitValid = 0;
    @(posedge clock); #1;
    n = 0; stall_left = 0; stalled = 0; did_rst = 0; post_rst = 0;
    while (n < 3000 && !seen_done && post_rst < 40) begin
      start = 0; reset = 0;
      if (rst_after >= 0 && !did_rst && wr_addr.size() == rst_after) begin
        reset = 1; did_rst = 1;
      end
      if (n == ign_at && !did_rst) begin
        start = 1; charCode = 7'h42;
      end
      if (stall_at >= 0 && !stalled && m_taken == stall_at) begin
        stalled = 1; stall_left = stall_len;
      end
      bitIn = (m_taken < 128) ? rows[m_taken/8][7-(m_taken%8)] : 1'b0;
      if (stall_left > 0) begin
        bitValid = 0; stall_left--;
      end else begin
        bitValid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(posedge clock); #1;
      n++;
      if (did_rst) post_rst++;
    end
    start = 0; reset = 0; bitValid = 0;
    if (rst_after < 0) check("done_seen", seen_done, 1);
  endtask

  initial begin
    int rst_at;
    repeat (1) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bitReady", bitReady, 0);
    check("rst_ramWrEn", ramWrEn, 0);
    check("rst_ramAddr", ramAddr, 0);
    check("rst_ramWrData", ramWrData, 0);
`ifdef GLYPH_WRITER_READBACK_EN
    check("rst_ramRdEn", ramRdEn, 0);
    check("rst_verifyErr", verifyErr, 0);
`endif
    @(posedge clock); #1;
    reset = 0; chk_en = 1;

    // streaming load, every row 0x18
    for (int r = 0; r < 16; r++) rows[r] = 8'h18;
    run_load(7'h41, 0, -1, 0, -1, -1);
    check("stream_done_cycle", done_off, DONE_OFF);
    check("stream_busy_at_done", busy_at_done, 0);
    check("stream_wr_count", wr_addr.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check("stream_addr", wr_addr[i], 11'h410 + 11'(i));
      check("stream_data", wr_data[i], 8'h18);
    end

    // 5-cycle stall after bit 3 of row 2, plus an ignored start with code 0x42
    run_load(7'h41, 0, 19, 5, 30, -1);
    check("stall_done_cycle", done_off, DONE_OFF + 5);
    check("stall_row2_data", wr_data[2], 8'h18);
    for (int i = 0; i < 16; i++) check("ignored_start_code", wr_addr[i][10:4], 7'h41);

    // reset right after the row-5 write abandons the load
    run_load(7'h41, 0, -1, 0, -1, 6);
    check("midrst_wr_count", wr_addr.size(), 6);
    check("midrst_last_addr", wr_addr[5], 11'h415);
    check("midrst_no_done", seen_done, 0);
    @(negedge clock);
    check("midrst_ramAddr", ramAddr, 0);
    @(posedge clock); #1;
    run_load(7'h41, 0, -1, 0, -1, -1);
    check("restart_first_addr", wr_addr[0], 11'h410);
    check("restart_done_cycle", done_off, DONE_OFF);

    // bit order
    for (int r = 0; r < 16; r++) rows[r] = 8'($urandom);
    rows[0] = 8'h81; rows[1] = 8'hC0;
    run_load(7'h13, 0, -1, 0, -1, -1);
    check("bitorder_81", wr_data[0], 8'h81);
    check("bitorder_C0", wr_data[1], 8'hC0);

`ifdef GLYPH_WRITER_READBACK_EN
    // readback with row 7 corrupted by the RAM
    for (int r = 0; r < 16; r++) rows[r] = 8'h18;
    corrupt7 = 1;
    run_load(7'h41, 0, -1, 0, -1, -1);
    check("rb_done_cycle", done_off, 177);
    check("rb_err_first_cycle", err_first, 88);
    check("rb_err_held", err_at_done, 1);
    corrupt7 = 0;
`endif

    // randomized loads
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < 16; r++) rows[r] = 8'($urandom);
`ifdef GLYPH_WRITER_READBACK_EN
      corrupt7 = ($urandom_range(0, 1) == 1);
`endif
      rst_at = (it == 3 || it == 6) ? int'($urandom_range(1, 14)) : -1;
      run_load(7'($urandom), 1, -1, 0, int'($urandom_range(5, 100)), rst_at);
      if (rst_at < 0) check("rand_wr_count", wr_addr.size(), 16);
      else check("rand_rst_wr_count", wr_addr.size(), rst_at);
      @(posedge clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
